// File: rtl/aibnd_txdrv_seq.sv
// Transmit driver leg sequencer: accepts a mode/strength request, releases the
// weak pull, ramps P/N leg counts one step per RAMP_DIV cycles, then applies the pull.
module aibnd_txdrv_seq #(
  parameter  int NLEG     = 16,
  parameter  int RAMP_DIV = 4,
  localparam int CW       = $clog2(NLEG + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cfg_req,
  input  logic [1:0]      cfg_mode,
  input  logic [CW-1:0]   cfg_pstr,
  input  logic [CW-1:0]   cfg_nstr,
  output logic            cfg_ack,
  output logic            busy,
  output logic            sat,
  output logic [NLEG-1:0] pdrv_en,
  output logic [NLEG-1:0] ndrv_enb,
  output logic            weak_pulldownen,
  output logic            weak_pullupenb
);

  localparam int            DIV_W  = 8;
  localparam logic [CW-1:0] NLEG_C = CW'(NLEG);
  localparam logic [1:0]    MODE_PULLDOWN = 2'b01;
  localparam logic [1:0]    MODE_PULLUP   = 2'b10;
  localparam logic [1:0]    MODE_DRIVE    = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RELEASE,
    S_RAMP,
    S_APPLY,
    S_ACK
  } state_t;

  state_t            r_state;
  logic [1:0]        r_mode;
  logic [CW-1:0]     r_ptgt;
  logic [CW-1:0]     r_ntgt;
  logic [CW-1:0]     r_pcnt;
  logic [CW-1:0]     r_ncnt;
  logic [DIV_W-1:0]  r_div;
  logic              r_cfg_ack;
  logic              r_busy;
  logic              r_sat;
  logic [NLEG-1:0]   r_pdrv_en;
  logic [NLEG-1:0]   r_ndrv_enb;
  logic              r_wpd;
  logic              r_wpub;

  logic [CW-1:0]     w_ptgt_req;
  logic [CW-1:0]     w_ntgt_req;
  logic              w_ovf_req;
  logic [CW-1:0]     w_pcnt_step;
  logic [CW-1:0]     w_ncnt_step;
  logic              w_step_done;
  logic              w_div_tc;

  // Thermometer code: leg i is on when i is below the count.
  function automatic logic [NLEG-1:0] f_therm(input logic [CW-1:0] cnt);
    logic [NLEG-1:0] v;
    for (int i = 0; i < NLEG; i++) v[i] = (i < int'(cnt));
    return v;
  endfunction

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_ovf_req  = 1'b0;
    w_ptgt_req = '0;
    w_ntgt_req = '0;
    if (cfg_mode == MODE_DRIVE) begin
      w_ovf_req  = (cfg_pstr > NLEG_C) || (cfg_nstr > NLEG_C);
      w_ptgt_req = (cfg_pstr > NLEG_C) ? NLEG_C : cfg_pstr;
      w_ntgt_req = (cfg_nstr > NLEG_C) ? NLEG_C : cfg_nstr;
    end

    w_pcnt_step = r_pcnt;
    if (r_pcnt < r_ptgt)      w_pcnt_step = r_pcnt + CW'(1);
    else if (r_pcnt > r_ptgt) w_pcnt_step = r_pcnt - CW'(1);

    w_ncnt_step = r_ncnt;
    if (r_ncnt < r_ntgt)      w_ncnt_step = r_ncnt + CW'(1);
    else if (r_ncnt > r_ntgt) w_ncnt_step = r_ncnt - CW'(1);

    w_step_done = (w_pcnt_step == r_ptgt) && (w_ncnt_step == r_ntgt);
    w_div_tc    = (r_div == DIV_W'(RAMP_DIV - 1));
  end

  // NOTE: reset is synchronous, so it lives inside the clocked branch; all state uses <=.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_mode     <= '0;
      r_ptgt     <= '0;
      r_ntgt     <= '0;
      r_pcnt     <= '0;
      r_ncnt     <= '0;
      r_div      <= '0;
      r_cfg_ack  <= 1'b0;
      r_busy     <= 1'b0;
      r_sat      <= 1'b0;
      r_pdrv_en  <= '0;
      r_ndrv_enb <= '1;
      r_wpd      <= 1'b0;
      r_wpub     <= 1'b1;
    end else begin
      r_cfg_ack <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cfg_req) begin
            r_mode  <= cfg_mode;
            r_ptgt  <= w_ptgt_req;
            r_ntgt  <= w_ntgt_req;
            r_sat   <= w_ovf_req;
            r_busy  <= 1'b1;
            r_state <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          r_wpd  <= 1'b0;
          r_wpub <= 1'b1;
          r_div  <= '0;
          if (r_pcnt == r_ptgt && r_ncnt == r_ntgt) r_state <= S_APPLY;
          else                                      r_state <= S_RAMP;
        end
        S_RAMP: begin
          if (w_div_tc) begin
            r_div      <= '0;
            r_pcnt     <= w_pcnt_step;
            r_ncnt     <= w_ncnt_step;
            r_pdrv_en  <= f_therm(w_pcnt_step);
            r_ndrv_enb <= ~f_therm(w_ncnt_step);
            if (w_step_done) r_state <= S_APPLY;
          end else begin
            r_div <= r_div + DIV_W'(1);
          end
        end
        S_APPLY: begin
          // Targets are zero for both pull modes, so the legs are already off here.
          case (r_mode)
            MODE_PULLDOWN: begin r_wpd <= 1'b1; r_wpub <= 1'b1; end
            MODE_PULLUP:   begin r_wpd <= 1'b0; r_wpub <= 1'b0; end
            default:       begin r_wpd <= 1'b0; r_wpub <= 1'b1; end
          endcase
          r_state <= S_ACK;
        end
        S_ACK: begin
          r_cfg_ack <= 1'b1;
          r_busy    <= 1'b0;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cfg_ack         = r_cfg_ack;
  assign busy            = r_busy;
  assign sat             = r_sat;
  assign pdrv_en         = r_pdrv_en;
  assign ndrv_enb        = r_ndrv_enb;
  assign weak_pulldownen = r_wpd;
  assign weak_pullupenb  = r_wpub;

endmodule

// File: tb/tb_aibnd_txdrv_seq.sv
// Self-checking bench for aibnd_txdrv_seq: directed scenarios plus random requests
// compared cycle by cycle against a schedule derived from step counts.
module tb_aibnd_txdrv_seq;

  localparam int NLEG = 16;
  localparam int RD   = 4;
  localparam int CW   = $clog2(NLEG + 1);

  logic            clk;
  logic            rst;
  logic            cfg_req;
  logic [1:0]      cfg_mode;
  logic [CW-1:0]   cfg_pstr;
  logic [CW-1:0]   cfg_nstr;
  logic            cfg_ack;
  logic            busy;
  logic            sat;
  logic [NLEG-1:0] pdrv_en;
  logic [NLEG-1:0] ndrv_enb;
  logic            weak_pulldownen;
  logic            weak_pullupenb;

  int n_checks = 0;
  int n_fail   = 0;

  // Model of the settled state between sequences.
  int         m_p   = 0;
  int         m_n   = 0;
  logic [1:0] m_wk  = 2'b01;
  logic       m_sat = 1'b0;

  aibnd_txdrv_seq #(.NLEG(NLEG), .RAMP_DIV(RD)) dut (
    .clk             (clk),
    .rst             (rst),
    .cfg_req         (cfg_req),
    .cfg_mode        (cfg_mode),
    .cfg_pstr        (cfg_pstr),
    .cfg_nstr        (cfg_nstr),
    .cfg_ack         (cfg_ack),
    .busy            (busy),
    .sat             (sat),
    .pdrv_en         (pdrv_en),
    .ndrv_enb        (ndrv_enb),
    .weak_pulldownen (weak_pulldownen),
    .weak_pullupenb  (weak_pullupenb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [NLEG-1:0] legs(input int n);
    logic [63:0] v;
    v = (64'd1 << n) - 64'd1;
    return v[NLEG-1:0];
  endfunction

  function automatic logic [1:0] wk_of(input logic [1:0] mode);
    case (mode)
      2'b01:   return 2'b11;
      2'b10:   return 2'b00;
      default: return 2'b01;
    endcase
  endfunction

  task automatic check_reset_vals(input string tag);
    n_checks++;
    if (pdrv_en !== '0 || ndrv_enb !== '1 || {weak_pulldownen, weak_pullupenb} !== 2'b01 ||
        busy !== 1'b0 || cfg_ack !== 1'b0 || sat !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: got p=%h n=%h wk=%b busy=%b ack=%b sat=%b exp p=0 n=all1 wk=01 busy=0 ack=0 sat=0",
               tag, pdrv_en, ndrv_enb, {weak_pulldownen, weak_pullupenb}, busy, cfg_ack, sat);
    end
  endtask

  // Issues one request at the current negedge and checks every cycle after E0.
  task automatic run_seq(input string tag, input logic [1:0] mode, input int ps, input int ns,
                         input bit hold, input int abort_at, input int tail, output int ack_c);
    int tp, tn, dp, dn, adp, adn, sp, sn, nsteps, last, k, ep, en;
    logic       ovf;
    logic [1:0] ewk, pair;
    logic       ebusy, eack;
    tp  = (mode == 2'b11) ? ((ps > NLEG) ? NLEG : ps) : 0;
    tn  = (mode == 2'b11) ? ((ns > NLEG) ? NLEG : ns) : 0;
    ovf = (mode == 2'b11) && (ps > NLEG || ns > NLEG);
    dp  = tp - m_p;  dn = tn - m_n;
    adp = (dp < 0) ? -dp : dp;  adn = (dn < 0) ? -dn : dn;
    sp  = (dp < 0) ? -1 : 1;    sn  = (dn < 0) ? -1 : 1;
    nsteps = (adp > adn) ? adp : adn;
    last   = 3 + nsteps * RD;
    ack_c  = -1;

    cfg_req  = 1'b1;
    cfg_mode = mode;
    cfg_pstr = CW'(ps);
    cfg_nstr = CW'(ns);
    @(posedge clk);
    for (int c = 0; c <= last + tail; c++) begin
      @(negedge clk);
      k   = (c < 1) ? 0 : (((c - 1) / RD < nsteps) ? (c - 1) / RD : nsteps);
      ep  = m_p + sp * ((k < adp) ? k : adp);
      en  = m_n + sn * ((k < adn) ? k : adn);
      ewk = (c == 0) ? m_wk : ((c <= 1 + nsteps * RD) ? 2'b01 : wk_of(mode));
      ebusy = (c < last);
      eack  = (c == last);
      pair  = {weak_pulldownen, weak_pullupenb};
      if (cfg_ack === 1'b1 && ack_c < 0) ack_c = c;

      n_checks++;
      if (pdrv_en !== legs(ep)) begin
        n_fail++; $display("FAIL %s c=%0d pdrv_en got %h exp %h", tag, c, pdrv_en, legs(ep));
      end
      n_checks++;
      if (ndrv_enb !== ~legs(en)) begin
        n_fail++; $display("FAIL %s c=%0d ndrv_enb got %h exp %h", tag, c, ndrv_enb, ~legs(en));
      end
      n_checks++;
      if (pair !== ewk) begin
        n_fail++; $display("FAIL %s c=%0d weak got %b exp %b", tag, c, pair, ewk);
      end
      n_checks++;
      if (busy !== ebusy) begin
        n_fail++; $display("FAIL %s c=%0d busy got %b exp %b", tag, c, busy, ebusy);
      end
      n_checks++;
      if (cfg_ack !== eack) begin
        n_fail++; $display("FAIL %s c=%0d cfg_ack got %b exp %b", tag, c, cfg_ack, eack);
      end
      n_checks++;
      if (sat !== ovf) begin
        n_fail++; $display("FAIL %s c=%0d sat got %b exp %b", tag, c, sat, ovf);
      end
      n_checks++;
      if (pair === 2'b10 || (pair !== 2'b01 && (pdrv_en !== '0 || ndrv_enb !== '1))) begin
        n_fail++; $display("FAIL %s c=%0d weak/leg overlap weak=%b p=%h n=%h", tag, c, pair, pdrv_en, ndrv_enb);
      end

      if (c == abort_at) begin
        cfg_req = 1'b0;
        rst     = 1'b1;
        @(negedge clk);
        check_reset_vals({tag, " abort"});
        rst = 1'b0;
        m_p = 0; m_n = 0; m_wk = 2'b01; m_sat = 1'b0;
        for (int j = 0; j < 3; j++) begin
          @(negedge clk);
          check_reset_vals({tag, " post-abort"});
        end
        ack_c = -1;
        return;
      end

      // Fields change while busy; the latched request must not be affected.
      if ((!hold && c == 0) || (hold && c == last)) cfg_req = 1'b0;
      if (c < last) begin
        cfg_mode = 2'($urandom_range(0, 3));
        cfg_pstr = CW'($urandom_range(0, NLEG + 3));
        cfg_nstr = CW'($urandom_range(0, NLEG + 3));
      end
    end
    m_p = tp; m_n = tn; m_wk = wk_of(mode); m_sat = ovf;
  endtask

  task automatic test_reset;
    rst      = 1'b1;
    cfg_req  = 1'b1;
    cfg_mode = 2'b11;
    cfg_pstr = CW'(5);
    cfg_nstr = CW'(5);
    repeat (3) begin
      @(negedge clk);
      check_reset_vals("reset");
    end
    rst     = 1'b0;
    cfg_req = 1'b0;
    @(negedge clk);
    check_reset_vals("reset release idle");
    m_p = 0; m_n = 0; m_wk = 2'b01; m_sat = 1'b0;
  endtask

  task automatic test_drive_ramp;
    int ack_c;
    run_seq("drive_4_4", 2'b11, 4, 4, 1'b0, -1, 1, ack_c);
    n_checks++;
    if (ack_c !== 19) begin
      n_fail++; $display("FAIL drive_4_4 ack cycle got %0d exp 19", ack_c);
    end
  endtask

  task automatic test_pulldown;
    int ack_c;
    run_seq("pulldown", 2'b01, 0, 0, 1'b0, -1, 1, ack_c);
    n_checks++;
    if (ack_c !== 19) begin
      n_fail++; $display("FAIL pulldown ack cycle got %0d exp 19", ack_c);
    end
  endtask

  task automatic test_saturation;
    int ack_c;
    run_seq("sat_over", 2'b11, NLEG + 3, 5, 1'b0, -1, 1, ack_c);
    n_checks++;
    if (pdrv_en !== {NLEG{1'b1}} || sat !== 1'b1) begin
      n_fail++; $display("FAIL sat_over final got p=%h sat=%b exp p=all1 sat=1", pdrv_en, sat);
    end
    run_seq("sat_clear", 2'b11, 3, 3, 1'b0, -1, 1, ack_c);
    n_checks++;
    if (sat !== 1'b0) begin
      n_fail++; $display("FAIL sat_clear got %b exp 0", sat);
    end
  endtask

  task automatic test_simultaneous;
    int ack_c;
    logic [NLEG-1:0] exp_n;
    exp_n = ~NLEG'(3);
    run_seq("sim_2_6", 2'b11, 2, 6, 1'b0, -1, 1, ack_c);
    run_seq("sim_6_2", 2'b11, 6, 2, 1'b0, -1, 1, ack_c);
    n_checks++;
    if (ndrv_enb !== exp_n || ack_c !== 3 + 4 * RD) begin
      n_fail++; $display("FAIL sim_6_2 final ndrv_enb got %h exp %h ack %0d exp %0d",
                         ndrv_enb, exp_n, ack_c, 3 + 4 * RD);
    end
  endtask

  task automatic test_held_req;
    int ack_c;
    run_seq("held_req", 2'b11, 5, 1, 1'b1, -1, 4, ack_c);
    run_seq("same_state", 2'b11, 5, 1, 1'b0, -1, 1, ack_c);
    n_checks++;
    if (ack_c !== 3) begin
      n_fail++; $display("FAIL same_state ack cycle got %0d exp 3", ack_c);
    end
  endtask

  task automatic test_pullup_to_hiz;
    int ack_c;
    run_seq("to_pullup", 2'b10, 7, 7, 1'b0, -1, 1, ack_c);
    run_seq("pullup_hiz", 2'b00, 0, 0, 1'b0, -1, 1, ack_c);
    n_checks++;
    if (ack_c !== 3) begin
      n_fail++; $display("FAIL pullup_hiz ack cycle got %0d exp 3", ack_c);
    end
  endtask

  task automatic test_abort;
    int ack_c;
    run_seq("abort_ramp", 2'b11, 8, 8, 1'b0, 6, 1, ack_c);
  endtask

  task automatic test_back_to_back_random;
    int ack_c;
    for (int it = 0; it < 30; it++) begin
      run_seq("random", 2'($urandom_range(0, 3)), int'($urandom_range(0, NLEG + 3)),
              int'($urandom_range(0, NLEG + 3)), ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 10)) : -1,
              int'($urandom_range(0, 2)), ack_c);
    end
  endtask

  initial begin
    rst      = 1'b1;
    cfg_req  = 1'b0;
    cfg_mode = 2'b00;
    cfg_pstr = '0;
    cfg_nstr = '0;
    test_reset();
    test_drive_ramp();
    test_pulldown();
    test_saturation();
    test_simultaneous();
    test_held_req();
    test_pullup_to_hiz();
    test_abort();
    test_back_to_back_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/aibnd_txdrv_seq.md
AIBND_TXDRV_SEQ -- requirements
Module: aibnd_txdrv_seq

Interface
REQ-001 SHALL have parameter NLEG, default 16, meaning number of P and N driver legs (2..64).
REQ-002 SHALL have parameter RAMP_DIV, default 4, meaning clock cycles per leg step (1..255).
REQ-003 SHALL have localparam CW = $clog2(NLEG+1), meaning the strength code width.
REQ-004 SHALL have port clk, input, 1, the single clock.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port cfg_req, input, 1, configuration request, sampled only in IDLE.
REQ-007 SHALL have port cfg_mode, input, 2, mode: 00 hi-Z, 01 weak pulldown, 10 weak pullup, 11 drive.
REQ-008 SHALL have port cfg_pstr, input, CW, requested P leg count.
REQ-009 SHALL have port cfg_nstr, input, CW, requested N leg count.
REQ-010 SHALL have port cfg_ack, output, 1, one-cycle completion pulse.
REQ-011 SHALL have port busy, output, 1, sequence in progress.
REQ-012 SHALL have port sat, output, 1, sticky flag: a requested strength exceeded NLEG.
REQ-013 SHALL have port pdrv_en, output, NLEG, P leg enables, active-high thermometer code.
REQ-014 SHALL have port ndrv_enb, output, NLEG, N leg enables, active-low thermometer code.
REQ-015 SHALL have port weak_pulldownen, output, 1, weak pull control.
REQ-016 SHALL have port weak_pullupenb, output, 1, weak pull control.

Function
REQ-017 SHALL register every output; no combinational path from inputs to outputs.
REQ-018 SHALL keep internal counts pcnt and ncnt (0..NLEG) with pdrv_en[i]=(i<pcnt) and ndrv_enb[i]=~(i<ncnt).
REQ-019 SHALL encode weak pull as: pulldown = (weak_pulldownen 1, weak_pullupenb 1); pullup = (0,0); off = (0,1); the code (1,0) SHALL never be driven.
REQ-020 SHALL have the FSM states IDLE, RELEASE, RAMP, APPLY and ACK.
REQ-021 SHALL, in IDLE with cfg_req=1 at edge E0, latch mode and targets and enter RELEASE; busy=1 after E0.
REQ-022 SHALL set targets to min(cfg_pstr,NLEG) and min(cfg_nstr,NLEG) when mode=11, and to 0/0 otherwise.
REQ-023 SHALL set sat after E0 if mode=11 and either strength exceeds NLEG; sat clears only on the next accepted request without overflow.
REQ-024 SHALL, in RELEASE, drive the weak pull to off after E1, then enter RAMP.
REQ-025 SHALL, in RAMP, use a divider counting 0..RAMP_DIV-1, and at each terminal count move each of pcnt and ncnt one step toward its target, independently and simultaneously.
REQ-026 SHALL make step k visible after edge E(1+k*RAMP_DIV); for n = max(|dp|,|dn|) steps, APPLY is entered at E(1+n*RAMP_DIV), or at E1 when n=0.
REQ-027 SHALL, in APPLY, drive the weak pull per the latched mode (off for 00 and 11) after the next edge, then enter ACK.
REQ-028 SHALL, in ACK, hold cfg_ack=1 for exactly one cycle, drive busy=0 on the same edge, and return to IDLE.
REQ-029 SHALL never assert a weak pull while pcnt or ncnt is nonzero.
REQ-030 SHALL ignore cfg_req while busy, with no queueing, and SHALL keep cfg_ack low on ignored requests.
REQ-031 SHALL allow a new request to be accepted in the cycle after ACK.
REQ-032 SHALL, on a request equal to the current state, still perform RELEASE/APPLY/ACK with zero steps.
REQ-033 SHALL reset the divider on entry to RAMP.

Reset
REQ-034 SHALL, on rst=1 at any clock edge and in any state, apply: state IDLE, pcnt=ncnt=0, pdrv_en all 0, ndrv_enb all 1, weak pull off (0,1), busy=0, cfg_ack=0, sat=0, divider 0.
REQ-035 SHALL abort a sequence in progress on mid-operation reset, with no ack issued.

Verification
REQ-036 SHALL cover: reset, then req with mode 11, pstr 4, nstr 4, RAMP_DIV 4 -> pdrv_en steps 0x1,0x3,0x7,0xF after E5,E9,E13,E17; ack high in cycle after E19.
REQ-037 SHALL cover: from drive 4/4, req mode 01 -> legs ramp to 0 over 16 cycles; pulldown (1,1) appears only after pcnt=ncnt=0; ack 2 cycles later.
REQ-038 SHALL cover: req mode 11 with pstr = NLEG+3 -> sat=1, pdrv_en saturates at all ones; next valid req clears sat.
REQ-039 SHALL cover: from drive 2 P / 6 N, req 6 P / 2 N -> P and N counts step simultaneously; 4 steps; ndrv_enb ends at ~0x0003.
REQ-040 SHALL cover: cfg_req held high during busy -> single ack, no second sequence; rst asserted mid-RAMP -> all outputs at reset values after that edge, no ack.
REQ-041 SHALL cover: weak pullup active, req mode 00 -> (0,1) after E1, zero steps, ack in the cycle after E3.
